// File: rtl/remote_cmd_pkg.sv
// rtl/remote_cmd_pkg.sv - shared opcodes, ack byte, FSM states and timeout limits
// for the remote command sequencer.
package remote_cmd_pkg;

  localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
  localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
  localparam logic [7:0] CMD_SET_YAW   = 8'h04;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;
  localparam logic [7:0] CMD_EMER_LAND = 8'h07;
  localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_POS_ACK  = 8'hA5;

  localparam int TMO_W = 20;
  // Terminal timer values: the wait lasts exactly 4096 or 2^20 cycles.
  localparam logic [TMO_W-1:0] TMO_FAST_LAST = 20'd4095;
  localparam logic [TMO_W-1:0] TMO_SLOW_LAST = 20'hFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_CHECK
  } seq_state_t;

  function automatic logic [TMO_W-1:0] tmo_last(input bit fast);
    return fast ? TMO_FAST_LAST : TMO_SLOW_LAST;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command queue whose head stays resident until popped; supports
// dropping everything behind the head in the same cycle as a pop and/or push.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   DUT_clr_cmd_rdy,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush_tail,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n, wr_n, wr_addr;
  logic [CW-1:0] cnt_n;
  logic          do_push;

  // Ordering within a cycle: flush tail, then pop head, then append the push.
  always_comb begin
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    cnt_n   = count;
    do_push = 1'b0;
    if (flush_tail && count != '0) begin
      wr_n  = rd_ptr + AW'(1);
      cnt_n = CW'(1);
    end
    if (pop && cnt_n != '0) begin
      rd_n  = rd_ptr + AW'(1);
      cnt_n = cnt_n - CW'(1);
    end
    wr_addr = wr_n;
    if (push && cnt_n < CW'(DEPTH)) begin
      do_push = 1'b1;
      wr_n    = wr_n + AW'(1);
      cnt_n   = cnt_n + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge DUT_clr_cmd_rdy) begin
    if (DUT_clr_cmd_rdy) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count  <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/remote_cmd_seq.sv
// rtl/remote_cmd_seq.sv - issues queued commands to RemoteComm one at a time,
// retrying on NACK/timeout; emergency land pre-empts the backlog.
module remote_cmd_seq
  import remote_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY  = 3,
  parameter int FAST_SIM   = 0
) (
  input  logic                          clk,
  input  logic                          DUT_clr_cmd_rdy,
  input  logic                          req_vld,
  input  logic [7:0]                    req_cmd,
  input  logic [15:0]                   req_data,
  output logic                          req_rdy,
  input  logic                          flush,
  output logic                          send_cmd,
  output logic [7:0]                    cmd,
  output logic [15:0]                   data,
  input  logic                          cmd_sent,
  input  logic                          resp_rdy,
  input  logic [7:0]                    resp,
  output logic                          clr_resp_rdy,
  output logic                          done,
  output logic                          done_ok,
  output logic [7:0]                    done_cmd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   q_cnt
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = tmo_last(FAST_SIM != 0);

  seq_state_t        state, state_n;
  logic [RW-1:0]     retry_cnt;
  logic [TMO_W-1:0]  timer;
  logic [7:0]        resp_q;
  logic              abort_q, abort_now, abort_set;
  logic              full, empty, emer, push, flush_tail, pop;
  logic              load, retry_inc, tmo_hit, resp_latch, tmo, clr_int;
  logic [23:0]       head;

  assign emer       = req_vld && (req_cmd == CMD_EMER_LAND);
  assign push       = req_vld && (!full || emer);
  assign flush_tail = flush || emer;
  assign req_rdy    = !full;
  assign busy       = (state != S_IDLE);
  assign tmo        = (timer == TMO_LAST);
  // An emergency arriving while a head is (or is about to be) in flight cancels its retries.
  assign abort_set  = emer && (busy || !empty);
  assign abort_now  = abort_q || (emer && busy);

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(24)) u_fifo (
    .clk             (clk),
    .DUT_clr_cmd_rdy (DUT_clr_cmd_rdy),
    .push            (push),
    .push_data       ({req_cmd, req_data}),
    .pop             (pop),
    .flush_tail      (flush_tail),
    .head_data       (head),
    .count           (q_cnt),
    .full            (full),
    .empty           (empty)
  );

  always_ff @(posedge clk or posedge DUT_clr_cmd_rdy) begin
    if (DUT_clr_cmd_rdy) state <= S_IDLE;
    else                 state <= state_n;
  end

  always_comb begin
    state_n    = state;
    send_cmd   = 1'b0;
    clr_int    = 1'b0;
    done       = 1'b0;
    done_ok    = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    retry_inc  = 1'b0;
    tmo_hit    = 1'b0;
    resp_latch = 1'b0;
    case (state)
      S_IDLE: begin
        clr_int = resp_rdy;
        if (!empty) begin
          load    = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        send_cmd = 1'b1;
        clr_int  = resp_rdy;
        state_n  = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (cmd_sent) begin
          state_n = S_WAIT_RESP;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_WAIT_RESP: begin
        if (resp_rdy) begin
          clr_int    = 1'b1;
          resp_latch = 1'b1;
          state_n    = S_CHECK;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (resp_q != RESP_POS_ACK && !abort_now && retry_cnt < RW'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          state_n   = S_SEND;
        end else begin
          done    = 1'b1;
          done_ok = (resp_q == RESP_POS_ACK) && !abort_now;
          pop     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stale-response clearing in IDLE must stay quiet while reset is held.
  assign clr_resp_rdy = clr_int && !DUT_clr_cmd_rdy;
  assign done_cmd     = done ? cmd : 8'h00;

  always_ff @(posedge clk or posedge DUT_clr_cmd_rdy) begin
    if (DUT_clr_cmd_rdy) begin
      cmd       <= '0;
      data      <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      resp_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      if (load) {cmd, data} <= head;
      if (load)           retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RW'(1);
      if (state == S_SEND)
        timer <= '0;
      else if (state == S_WAIT_SENT || state == S_WAIT_RESP)
        timer <= timer + TMO_W'(1);
      // A timeout leaves a non-ack byte behind so CHECK treats it as a NACK.
      if (resp_latch)   resp_q <= resp;
      else if (tmo_hit) resp_q <= 8'h00;
      if (abort_set)    abort_q <= 1'b1;
      else if (load)    abort_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// tb/tb_remote_cmd_seq.sv - directed bench for remote_cmd_seq (FAST_SIM=1, depth 4, 3 retries).
module tb_remote_cmd_seq;

  logic        clk = 1'b0;
  logic        DUT_clr_cmd_rdy = 1'b1;
  logic        req_vld = 1'b0;
  logic [7:0]  req_cmd = '0;
  logic [15:0] req_data = '0;
  logic        req_rdy;
  logic        flush = 1'b0;
  logic        send_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        clr_resp_rdy;
  logic        done, done_ok;
  logic [7:0]  done_cmd;
  logic        busy;
  logic [2:0]  q_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  remote_cmd_seq #(.FIFO_DEPTH(4), .MAX_RETRY(3), .FAST_SIM(1)) dut (
    .clk(clk), .DUT_clr_cmd_rdy(DUT_clr_cmd_rdy),
    .req_vld(req_vld), .req_cmd(req_cmd), .req_data(req_data), .req_rdy(req_rdy),
    .flush(flush), .send_cmd(send_cmd), .cmd(cmd), .data(data),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .done(done), .done_ok(done_ok), .done_cmd(done_cmd), .busy(busy), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_cmd) strobe_cnt++;
    if (done)     done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [15:0] d, input logic fl);
    req_vld = 1'b1; req_cmd = c; req_data = d; flush = fl;
    tick();
    req_vld = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_send(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (send_cmd !== 1'b1 && n < budget);
    chk("wait_send", 32'(send_cmd), 1);
  endtask

  // Called in SEND or WAIT_SENT; returns with the DUT in CHECK.
  task automatic respond(input logic [7:0] b);
    tick();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    resp_rdy = 1'b1; resp = b;
    tick();
    resp_rdy = 1'b0;
  endtask

  initial begin
    int n, s0, d0;

    // Reset state
    tick(); tick();
    chk("rst_req_rdy", 32'(req_rdy), 1);
    chk("rst_send",    32'(send_cmd), 0);
    chk("rst_cmd",     32'(cmd), 0);
    chk("rst_data",    32'(data), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_qcnt",    32'(q_cnt), 0);
    chk("rst_clr",     32'(clr_resp_rdy), 0);
    DUT_clr_cmd_rdy = 1'b0;
    tick();

    // Stale response in IDLE is cleared
    resp_rdy = 1'b1; #1;
    chk("stale_clr", 32'(clr_resp_rdy), 1);
    resp_rdy = 1'b0; #1;
    chk("stale_clr_off", 32'(clr_resp_rdy), 0);
    tick();

    // Single command, immediate ack
    push(8'h02, 16'h1337, 1'b0);
    chk("t1_qcnt", 32'(q_cnt), 1);
    chk("t1_busy_idle", 32'(busy), 0);
    s0 = strobe_cnt;
    wait_send(10, n);
    chk("t1_latency", 32'(n), 1);
    chk("t1_cmd",  32'(cmd), 'h02);
    chk("t1_data", 32'(data), 'h1337);
    chk("t1_busy", 32'(busy), 1);
    respond(8'hA5);
    chk("t1_done",     32'(done), 1);
    chk("t1_done_ok",  32'(done_ok), 1);
    chk("t1_done_cmd", 32'(done_cmd), 'h02);
    chk("t1_qcnt_ret", 32'(q_cnt), 1);
    tick();
    chk("t1_qcnt_after", 32'(q_cnt), 0);
    chk("t1_done_off",   32'(done), 0);
    chk("t1_strobes",    32'(strobe_cnt - s0), 1);

    // Two NACKs then ack
    push(8'h03, 16'h0102, 1'b0);
    s0 = strobe_cnt;
    wait_send(10, n);
    respond(8'h5A);
    chk("t2_no_done1", 32'(done), 0);
    wait_send(10, n);
    chk("t2_retry_lat", 32'(n), 1);
    respond(8'h5A);
    chk("t2_no_done2", 32'(done), 0);
    wait_send(10, n);
    respond(8'hA5);
    chk("t2_done",     32'(done), 1);
    chk("t2_done_ok",  32'(done_ok), 1);
    chk("t2_done_cmd", 32'(done_cmd), 'h03);
    chk("t2_strobes",  32'(strobe_cnt - s0), 3);
    tick();

    // No answer at all: four attempts spaced by timeouts, then failure
    push(8'h05, 16'h00FF, 1'b0);
    s0 = strobe_cnt;
    wait_send(10, n);
    for (int i = 0; i < 3; i++) begin
      wait_send(5000, n);
      chk("t3_gap", 32'(n >= 4096 && n <= 4100), 1);
    end
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("t3_done",     32'(done), 1);
    chk("t3_done_ok",  32'(done_ok), 0);
    chk("t3_done_cmd", 32'(done_cmd), 'h05);
    chk("t3_strobes",  32'(strobe_cnt - s0), 4);
    tick();
    chk("t3_qcnt", 32'(q_cnt), 0);

    // Full queue, rejected push, emergency pre-emption
    push(8'h02, 16'h0001, 1'b0);
    s0 = strobe_cnt;
    wait_send(10, n);
    push(8'h03, 16'h0002, 1'b0);
    push(8'h04, 16'h0003, 1'b0);
    push(8'h06, 16'h0004, 1'b0);
    chk("t4_full_qcnt", 32'(q_cnt), 4);
    chk("t4_req_rdy",   32'(req_rdy), 0);
    push(8'h08, 16'h0005, 1'b0);
    chk("t4_reject", 32'(q_cnt), 4);
    push(8'h07, 16'h0000, 1'b0);
    chk("t4_emer_qcnt", 32'(q_cnt), 2);
    chk("t4_emer_rdy",  32'(req_rdy), 1);
    respond(8'h5A);
    chk("t4_abort_done", 32'(done), 1);
    chk("t4_abort_ok",   32'(done_ok), 0);
    chk("t4_abort_cmd",  32'(done_cmd), 'h02);
    chk("t4_no_retry",   32'(strobe_cnt - s0), 1);
    tick();
    chk("t4_qcnt_pop", 32'(q_cnt), 1);
    wait_send(10, n);
    chk("t4_emer_lat", 32'(n), 1);
    chk("t4_emer_cmd", 32'(cmd), 'h07);
    respond(8'hA5);
    chk("t4_emer_ok",  32'(done_ok), 1);
    chk("t4_emer_dcmd", 32'(done_cmd), 'h07);
    tick();
    chk("t4_qcnt_end", 32'(q_cnt), 0);

    // Flush with a simultaneous push while the head is in flight
    push(8'h02, 16'h2222, 1'b0);
    wait_send(10, n);
    push(8'h03, 16'h3333, 1'b0);
    push(8'h05, 16'h4444, 1'b0);
    chk("t5_qcnt3", 32'(q_cnt), 3);
    push(8'h04, 16'hAAAA, 1'b1);
    chk("t5_qcnt2", 32'(q_cnt), 2);
    respond(8'hA5);
    chk("t5_head_ok",  32'(done_ok), 1);
    chk("t5_head_cmd", 32'(done_cmd), 'h02);
    tick();
    wait_send(10, n);
    chk("t5_next_cmd",  32'(cmd), 'h04);
    chk("t5_next_data", 32'(data), 'hAAAA);
    respond(8'hA5);
    chk("t5_next_done", 32'(done_cmd), 'h04);
    tick();
    chk("t5_qcnt_end", 32'(q_cnt), 0);

    // Reset while waiting for the response
    push(8'h06, 16'h5555, 1'b0);
    wait_send(10, n);
    tick();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    d0 = done_cnt;
    #2;
    DUT_clr_cmd_rdy = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cmd",  32'(cmd), 0);
    chk("t6_data", 32'(data), 0);
    chk("t6_qcnt", 32'(q_cnt), 0);
    chk("t6_send", 32'(send_cmd), 0);
    chk("t6_done", 32'(done), 0);
    tick(); tick();
    DUT_clr_cmd_rdy = 1'b0;
    tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    push(8'h03, 16'h0BAD, 1'b0);
    wait_send(10, n);
    chk("t6_lat",  32'(n), 1);
    chk("t6_cmd2", 32'(cmd), 'h03);
    chk("t6_dat2", 32'(data), 'h0BAD);
    respond(8'hA5);
    chk("t6_ok",   32'(done_ok), 1);
    chk("t6_dcmd", 32'(done_cmd), 'h03);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/remote_cmd_seq.md
# remote_cmd_seq

Remote-side command sequencer between the pilot/host logic and `RemoteComm`. It queues pending commands (opcode + 16-bit data) and issues them one at a time over the link. For each command it waits for the quad's response, checks it against the positive ack `0xA5`, and retries on NACK or timeout. An emergency-land request flushes the backlog and jumps to the head of the queue.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: queue entries; must be a power of 2, minimum 2.
- `MAX_RETRY`, default 3: re-sends allowed after the first attempt before the command is reported as failed.
- `FAST_SIM`, default 0: selects the response timeout. 1 gives 4096 cycles; 0 gives 2^20 cycles.

Ports:
- `clk`  in  1  system clock, rising edge.
- `DUT_clr_cmd_rdy`  in  1  reset; asynchronous, active-high.
- `req_vld`  in  1  host offers a command.
- `req_cmd`  in  8  opcode offered.
- `req_data`  in  16  payload offered.
- `req_rdy`  out  1  queue can accept; equals !full.
- `flush`  in  1  drops all queued, not-yet-issued entries.
- `send_cmd`  out  1  one-cycle strobe to `RemoteComm`.
- `cmd`  out  8  opcode to `RemoteComm`, held stable from `send_cmd` until completion.
- `data`  out  16  payload to `RemoteComm`, same hold rule as `cmd`.
- `cmd_sent`  in  1  `RemoteComm` finished transmitting all 3 bytes.
- `resp_rdy`  in  1  response byte available.
- `resp`  in  8  response byte.
- `clr_resp_rdy`  out  1  one-cycle strobe consuming `resp_rdy`.
- `done`  out  1  one-cycle pulse when a command retires.
- `done_ok`  out  1  valid with `done`; 1 means ack received.
- `done_cmd`  out  8  valid with `done`; opcode of the retired command.
- `busy`  out  1  FSM is not in IDLE.
- `q_cnt`  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
- Push: an entry is written when `req_vld & req_rdy`. The head entry stays in the queue while in flight and is popped only on retire.
- FSM states:
  - IDLE: if the queue is non-empty, load the head into `cmd`/`data`, clear the retry count, go to SEND.
  - SEND: assert `send_cmd` for one cycle, clear the timer, go to WAIT_SENT.
  - WAIT_SENT: on `cmd_sent`, go to WAIT_RESP.
  - WAIT_RESP: on `resp_rdy`, assert `clr_resp_rdy` and go to CHECK.
  - CHECK:
    - If `resp == 8'hA5`, retire with `done_ok=1`.
    - Otherwise, if retry count < `MAX_RETRY`, increment it and go to SEND.
    - Otherwise, retire with `done_ok=0`.
  - Retire: pulse `done`, pop the head, go to IDLE.
- Timeout: the timer runs in WAIT_SENT and WAIT_RESP. Reaching the limit is treated exactly like a NACK (retry or fail).
- Emergency: a push with `req_cmd == 8'h07` first discards every queued entry other than an in-flight head, then enqueues itself.
  - It is accepted even when the queue is full.
  - An in-flight command finishes its current attempt and is then retired as failed without retrying.
- Flush: discards all non-head entries. It does not affect an in-flight command. If `flush` and a push occur in the same cycle, the flush happens first and the pushed entry is kept.
- A stale `resp_rdy` seen in IDLE or SEND is cleared with `clr_resp_rdy` and not evaluated.

## Timing
- Reset values: all outputs 0, `req_rdy` 1, queue empty, FSM in IDLE, timer and retry count 0.
- A reset mid-transaction abandons the command with no `done` pulse.
- Latency: push at edge k → IDLE→SEND at k+1 → `send_cmd` high during cycle k+1..k+2.
- Retry latency: CHECK → SEND is 1 cycle; the resend strobe follows 2 cycles after `clr_resp_rdy`.
- Retire: `done` is coincident with the pop. `q_cnt` shows the decremented value the following cycle.
- Push and pop in the same cycle leave `q_cnt` unchanged. A full queue rejects a non-emergency push even when a pop occurs in that cycle.
- Full: `q_cnt == FIFO_DEPTH`. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Structure
- Package `remote_cmd_pkg`:
  - opcodes `CMD_SET_PTCH`..`CMD_MTRS_OFF` (0x02–0x08);
  - `RESP_POS_ACK = 8'hA5`;
  - the state enum;
  - timeout constants.
- Sub-module `cmd_fifo`: synchronous 24-bit FIFO providing push, pop, flush-all-but-head, count, full and empty.

## Test plan
- Push SET_PTCH/0x1337, reply 0xA5 → one `send_cmd` with `cmd=02`, `data=1337`; `done=1`, `done_ok=1`, `done_cmd=02`; `q_cnt` returns to 0.
- Reply 0x5A twice, then 0xA5 → three `send_cmd` strobes, then `done_ok=1`.
- Never answer with `FAST_SIM=1`, `MAX_RETRY=3` → four strobes spaced by 4096-cycle timeouts, then `done_ok=0`.
- Fill 4 entries; 5th non-emergency push → `req_rdy=0`, 5th entry not written. Push EMER_LAND → queue holds head + 0x07; `q_cnt=2`.
- `flush` with a simultaneous push of SET_YAW/0xAAAA while the head is in flight → `q_cnt=2`; the head still retires normally.
- Assert `DUT_clr_cmd_rdy` in WAIT_RESP → outputs zero within the same cycle, no `done`; the next push is serviced normally.
